// File: rtl/ex_stage_pkg.sv
// Shared opcode, result-class and divider-state definitions for the OpenMIPS execute stage.
// Optional feature macro used by div_unit: EX_DIV_EARLY_OUT_EN.
package ex_stage_pkg;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative radix-2 restoring divider (one quotient bit per cycle) with sign fix-up.
// EX_DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DIV_CNT_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic              i_annul,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output div_state_e        o_state,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem
);

    div_state_e            r_state;
    logic [DIV_CNT_W-1:0]  r_cnt;
    logic [2*DATA_W:0]     r_dividend;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_neg_q;
    logic                  r_neg_r;

    logic [DATA_W-1:0]     w_abs1;
    logic [DATA_W-1:0]     w_abs2;
    logic [DATA_W+1:0]     w_sub;
    logic [DATA_W-1:0]     w_q;
    logic [DATA_W-1:0]     w_r;

    assign w_abs1 = (i_signed && i_op1[DATA_W-1]) ? -i_op1 : i_op1;
    assign w_abs2 = (i_signed && i_op2[DATA_W-1]) ? -i_op2 : i_op2;

    // Partial remainder sits in [2W:W]; quotient bits shift in at bit 0.
    assign w_sub = {1'b0, r_dividend[2*DATA_W:DATA_W]} - {2'b00, r_divisor};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else if (i_annul) begin
            r_state <= DIV_FREE;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (i_start) begin
                        r_neg_q <= i_signed && (i_op1[DATA_W-1] ^ i_op2[DATA_W-1]);
                        r_neg_r <= i_signed && i_op1[DATA_W-1];
                        if (i_op2 == '0) begin
                            r_state <= DIV_BYZERO;
`ifdef EX_DIV_EARLY_OUT_EN
                        end else if (w_abs1 < w_abs2) begin
                            r_dividend <= {w_abs1, 1'b0, {DATA_W{1'b0}}};
                            r_state    <= DIV_END;
`endif
                        end else begin
                            r_dividend <= {{DATA_W{1'b0}}, w_abs1, 1'b0};
                            r_divisor  <= w_abs2;
                            r_cnt      <= '0;
                            r_state    <= DIV_ON;
                        end
                    end
                end
                DIV_BYZERO: begin
                    r_dividend <= '0;
                    r_state    <= DIV_END;
                end
                DIV_ON: begin
                    if (w_sub[DATA_W+1]) begin
                        r_dividend <= {r_dividend[2*DATA_W-1:0], 1'b0};
                    end else begin
                        r_dividend <= {w_sub[DATA_W-1:0], r_dividend[DATA_W-1:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == DIV_CNT_W'(DATA_W - 1)) begin
                        r_state <= DIV_END;
                    end
                end
                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

    assign w_q = r_dividend[DATA_W-1:0];
    assign w_r = r_dividend[2*DATA_W:DATA_W+1];

    always_comb begin
        o_state = r_state;
        o_ready = (r_state == DIV_END);
        o_quot  = r_neg_q ? -w_q : w_q;
        o_rem   = r_neg_r ? -w_r : w_r;
    end

endmodule

// File: rtl/ex_stage.sv
// OpenMIPS execute stage: single-cycle logic/shift ALU plus stalling DIV/DIVU via div_unit.
// Build with EX_DIV_EARLY_OUT_EN to enable the divider early-out path.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DIV_CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              annul_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    logic              w_is_div;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_logic;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_alu;
    logic              w_stall;
    logic              w_whilo;
    div_state_e        w_div_state;
    logic              w_div_ready;
    logic [DATA_W-1:0] w_div_quot;
    logic [DATA_W-1:0] w_div_rem;

    assign w_is_div = is_div_op(aluop_i);
    assign w_shamt  = reg1_i[4:0];

    div_unit #(
        .DATA_W    (DATA_W),
        .DIV_CNT_W (DIV_CNT_W)
    ) u_div (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_start (w_is_div & ~annul_i),
        .i_signed(aluop_i == EXE_DIV_OP),
        .i_annul (annul_i),
        .i_op1   (reg1_i),
        .i_op2   (reg2_i),
        .o_state (w_div_state),
        .o_ready (w_div_ready),
        .o_quot  (w_div_quot),
        .o_rem   (w_div_rem)
    );

    always_comb begin
        w_logic = '0;
        case (aluop_i)
            EXE_OR_OP:  w_logic = reg1_i | reg2_i;
            EXE_AND_OP: w_logic = reg1_i & reg2_i;
            EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
            EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
            default:    w_logic = '0;
        endcase
    end

    always_comb begin
        w_shift = '0;
        case (aluop_i)
            EXE_SLL_OP: w_shift = reg2_i << w_shamt;
            EXE_SRL_OP: w_shift = reg2_i >> w_shamt;
            EXE_SRA_OP: w_shift = $signed(reg2_i) >>> w_shamt;
            default:    w_shift = '0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (alusel_i)
            EXE_RES_LOGIC: w_alu = w_logic;
            EXE_RES_SHIFT: w_alu = w_shift;
            default:       w_alu = '0;
        endcase
    end

    // END deliberately drops the stall so the pipeline advances on the result cycle.
    always_comb begin
        w_stall = 1'b0;
        case (w_div_state)
            DIV_FREE:   w_stall = w_is_div;
            DIV_ON:     w_stall = 1'b1;
            DIV_BYZERO: w_stall = 1'b1;
            default:    w_stall = 1'b0;
        endcase
    end

    assign w_whilo = rst & w_div_ready & ~annul_i;

    always_comb begin
        wd_o       = rst ? wd_i : 5'd0;
        wreg_o     = rst & wreg_i & ~w_is_div;
        wdata_o    = rst ? w_alu : '0;
        whilo_o    = w_whilo;
        hi_o       = w_whilo ? w_div_rem  : '0;
        lo_o       = w_whilo ? w_div_quot : '0;
        stallreq_o = rst & w_stall;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the five-stage OpenMIPS pipeline; consumes the decoded operation, operands and write target issued by the decode stage through the id/ex register.
- Produces the GPR writeback triple. The same triple is returned to decode as the EX forwarding path.
- Logic and shift ops are single-cycle. DIV/DIVU run on an iterative radix-2 divider that stalls the pipeline and writes HI/LO.

Parameters:
- DATA_W, 32, operand/result width
- DIV_CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- aluop_i  in  8  operation code
- alusel_i  in  3  result class
- reg1_i  in  DATA_W  source operand 1; shift amount in [4:0]
- reg2_i  in  DATA_W  source operand 2
- wd_i  in  5  destination GPR address
- wreg_i  in  1  GPR write enable
- annul_i  in  1  flush; aborts an in-flight divide
- wd_o  out  5  destination GPR address
- wreg_o  out  1  GPR write enable
- wdata_o  out  DATA_W  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  DATA_W  remainder
- lo_o  out  DATA_W  quotient
- stallreq_o  out  1  hold PC, IF/ID and ID/EX

Behaviour:
- Reset (rst=0): every output is 0, the FSM goes to FREE, and all divider registers clear.
- Logic ops, same cycle as inputs:
  - OR/AND/XOR/NOR → reg1_i op reg2_i.
  - Shifts use shamt = reg1_i[4:0]: SLL = reg2<<shamt, SRL = reg2>>shamt (logical), SRA = arithmetic right shift of reg2.
  - wdata_o is selected by alusel_i; NOP class → 0.
- wd_o/wreg_o pass through combinationally, except on DIV/DIVU, where wreg_o=0.
- Divider FSM states: FREE, BYZERO, ON, END.
  - FREE: a DIV/DIVU op with annul_i=0 goes to BYZERO if reg2_i==0; otherwise latch |operands| (signed op only; DIVU uses raw values), clear cnt and go to ON.
  - ON: one restoring step per cycle on a 2*DATA_W+1 dividend register; cnt++; at cnt==DATA_W-1 go to END.
  - BYZERO: result q=r=0, then go to END.
  - END: present the result; always go to FREE on the next clock.
  - annul_i=1 in any state → FREE next clock, whilo_o=0.
- Sign fix-up, applied in END (DIV only):
  - quotient negated when the operand signs differ;
  - remainder takes the dividend's sign.
- stallreq_o:
  - high in FREE while a div op is present;
  - high in ON and BYZERO;
  - low in END, which lets the pipeline advance.
- Latency: nonzero divisor → DATA_W+2 cycles in EX (34 at default); zero divisor → 3 cycles.
- whilo_o=1 only in END with annul_i=0; hi_o/lo_o are valid only then.
- Back-to-back divides: the second op sees END→FREE first, so it restarts cleanly.
- Operand changes during ON are ignored; only the latched values are used.
- Divide results never write a GPR.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN.
- Defined: FREE checks |dividend| < |divisor| (nonzero divisor) and goes straight to END with q=0, r=dividend. Latency is 2 cycles.
- Undefined: this case takes the full iterative path, with identical results.

Decomposition:
- Shared package/defines file holds:
  - aluop codes EXE_OR_OP…EXE_SRA_OP, plus new EXE_DIV_OP and EXE_DIVU_OP;
  - alusel codes;
  - DIV_FREE/DIV_BYZERO/DIV_ON/DIV_END state encodings;
  - ZeroWord.
- Natural sub-module: div_unit. It contains the FSM, counter and datapath, with start/signed/annul/op1/op2 in and ready/result out. ex_stage keeps the ALU mux and stall logic.

Test Plan:
- OR: reg1=0x0000F0F0, reg2=0x00FF00FF, wd=3 → wdata=0x00FFF0FF, wreg=1, wd=3, same cycle, stallreq=0.
- SRA: shamt=4, reg2=0x80000010 → 0xF8000001. SLL: shamt=31, reg2=1 → 0x80000000.
- DIV: reg1=-7, reg2=2 → stallreq high 33 cycles, END: lo=0xFFFFFFFD, hi=0xFFFFFFFF, whilo=1, wreg=0. DIVU: 0xFFFFFFFF/16 → lo=0x0FFFFFFF, hi=0xF.
- Divide by zero: reg2=0 → 3 cycles, hi=lo=0, whilo=1. Then an immediate second DIV 100/7 → lo=14, hi=2.
- annul_i at iteration 10, then rst=0 mid-ON → FREE, whilo=0, stallreq=0; outputs clear asynchronously.
- Early-out: 3/10 → with EX_DIV_EARLY_OUT_EN defined, 2 cycles; without it, 34 cycles; both give lo=0, hi=3.
